// File: rtl/axis_level_fifo.sv
// Single-clock AXI4-Stream FIFO with exact occupancy and frame counts,
// programmable almost-full/almost-empty flags, flush and optional store-and-forward.
module axis_level_fifo #(
  parameter int DEPTH         = 1024,
  parameter int DATA_WIDTH    = 8,
  parameter int USER_WIDTH    = 1,
  parameter int STORE_FORWARD = 0,
  parameter int CNT_WIDTH     = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,

  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,

  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,

  input  logic [CNT_WIDTH-1:0]  cfg_almost_full,
  input  logic [CNT_WIDTH-1:0]  cfg_almost_empty,

  output logic [CNT_WIDTH-1:0]  status_level,
  output logic [CNT_WIDTH-1:0]  status_frames,
  output logic                  status_full,
  output logic                  status_empty,
  output logic                  status_almost_full,
  output logic                  status_almost_empty,
  output logic                  status_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int WW = USER_WIDTH + 1 + DATA_WIDTH;
  localparam bit SF_EN = (STORE_FORWARD != 0);
  localparam logic [CNT_WIDTH-1:0] FULL_LEVEL = CNT_WIDTH'(DEPTH);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);
  localparam logic [AW:0]          PTR_ONE    = (AW + 1)'(1);

  typedef enum logic {
    GATE_NORMAL,
    GATE_FALLBACK
  } gate_state_e;

  logic [WW-1:0]        mem_q [DEPTH];
  logic [AW:0]          wr_ptr_q, wr_ptr_d;
  logic [AW:0]          rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0] level_q, level_d;
  logic [CNT_WIDTH-1:0] frames_q, frames_d;
  logic                 out_valid_q, out_valid_d;
  logic [WW-1:0]        out_word_q, out_word_d;
  logic                 overflow_q, overflow_d;
  gate_state_e          gate_q, gate_d;

  logic          in_hs, out_hs, in_last, out_last;
  logic          ram_nonempty, is_full, gate_open, load;
  logic [WW-1:0] ram_word;
  logic          ram_last;

  assign is_full      = (level_q == FULL_LEVEL);
  assign ram_nonempty = (wr_ptr_q != rd_ptr_q);
  assign ram_word     = mem_q[rd_ptr_q[AW-1:0]];
  assign ram_last     = ram_word[DATA_WIDTH];

  assign s_axis_tready = !is_full && !flush && !rst;
  assign m_axis_tvalid = out_valid_q && !flush && !rst;
  assign m_axis_tdata  = out_word_q[DATA_WIDTH-1:0];
  assign m_axis_tlast  = out_word_q[DATA_WIDTH];
  assign m_axis_tuser  = out_word_q[WW-1 -: USER_WIDTH];

  assign in_hs    = s_axis_tvalid && s_axis_tready;
  assign out_hs   = m_axis_tvalid && m_axis_tready;
  assign in_last  = in_hs && s_axis_tlast;
  assign out_last = out_hs && m_axis_tlast;

  // A full FIFO with no complete frame would deadlock store-and-forward, so it cuts through.
  assign gate_open = !SF_EN || (frames_q != '0) || is_full || (gate_q == GATE_FALLBACK);
  assign load      = (!m_axis_tvalid || m_axis_tready) && ram_nonempty && gate_open;

  always_comb begin
    gate_d = gate_q;
    case (gate_q)
      GATE_NORMAL:   if (SF_EN && is_full && (frames_q == '0)) gate_d = GATE_FALLBACK;
      GATE_FALLBACK: if (load && ram_last) gate_d = GATE_NORMAL;
      default:       gate_d = GATE_NORMAL;
    endcase
    if (flush) gate_d = GATE_NORMAL;
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    frames_d    = frames_q;
    out_valid_d = out_valid_q;
    out_word_d  = out_word_q;
    overflow_d  = s_axis_tvalid && !s_axis_tready && !flush;
    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      level_d     = '0;
      frames_d    = '0;
      out_valid_d = 1'b0;
    end else begin
      if (in_hs) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (load) begin
        rd_ptr_d    = rd_ptr_q + PTR_ONE;
        out_word_d  = ram_word;
        out_valid_d = 1'b1;
      end else if (out_hs) begin
        out_valid_d = 1'b0;
      end
      case ({in_hs, out_hs})
        2'b10:   level_d = level_q + CNT_ONE;
        2'b01:   level_d = level_q - CNT_ONE;
        default: level_d = level_q;
      endcase
      case ({in_last, out_last})
        2'b10:   frames_d = frames_q + CNT_ONE;
        2'b01:   frames_d = frames_q - CNT_ONE;
        default: frames_d = frames_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      frames_q    <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      gate_q      <= GATE_NORMAL;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      frames_q    <= frames_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
      gate_q      <= gate_d;
    end
  end

  // Payload storage carries no reset; validity is tracked by pointers and out_valid_q.
  always_ff @(posedge clk) begin
    out_word_q <= out_word_d;
    if (in_hs) mem_q[wr_ptr_q[AW-1:0]] <= {s_axis_tuser, s_axis_tlast, s_axis_tdata};
  end

  assign status_level        = level_q;
  assign status_frames       = frames_q;
  assign status_full         = is_full;
  assign status_empty        = (level_q == '0);
  assign status_almost_full  = (level_q >= cfg_almost_full);
  assign status_almost_empty = (level_q <= cfg_almost_empty);
  assign status_overflow     = overflow_q;

endmodule
